// File: rtl/ifetch_queue.sv
// ifetch_queue: owns the fetch PC, drives a 1-cycle-latency instruction memory
// and buffers fetched words in a QDEPTH-entry first-word-fall-through queue.
module ifetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              ADDR_W   = 14,
   parameter int              QDEPTH   = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      prog_mode,
   input  logic                      redirect_valid,
   input  logic [XLEN-1:0]           redirect_pc,
   output logic                      imem_en,
   output logic [ADDR_W-1:0]         imem_addr,
   input  logic [XLEN-1:0]           imem_rdata,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [XLEN-1:0]           out_instr,
   output logic [XLEN-1:0]           out_pc,
   output logic [XLEN-1:0]           out_pc_plus4,
   output logic [$clog2(QDEPTH):0]   q_count,
   output logic                      fetch_err
);
   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] QD = CW'(QDEPTH);

   logic [XLEN-1:0] fpc, req_pc;
   logic            infl;
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic [CW-1:0]   count;
   logic [XLEN-1:0] q_instr [QDEPTH];
   logic [XLEN-1:0] q_pc    [QDEPTH];
   logic            flush, push, pop;

   assign flush = prog_mode | redirect_valid;
   // credit check counts the in-flight read so a response always has a free slot
   assign imem_en = rst & !flush & (count + CW'(infl) < QD);
   assign imem_addr = fpc[ADDR_W+1:2];
   assign push = infl & !flush;
   assign out_valid = count != '0;
   assign pop = out_valid & out_ready & !flush;
   assign out_instr = q_instr[rd_ptr];
   assign out_pc = q_pc[rd_ptr];
   assign out_pc_plus4 = out_pc + XLEN'(4);
   assign q_count = count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fpc       <= RESET_PC;
         req_pc    <= '0;
         infl      <= 1'b0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         fetch_err <= 1'b0;
      end else begin
         infl      <= imem_en;
         if (imem_en) req_pc <= fpc;
         fpc       <= prog_mode ? RESET_PC :
                      redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} :
                      imem_en ? fpc + XLEN'(4) : fpc;
         fetch_err <= fetch_err | (!prog_mode & redirect_valid & |redirect_pc[1:0]);
         if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_instr[wr_ptr] <= imem_rdata;
         q_pc[wr_ptr]    <= req_pc;
      end
   end

   assert property (@(posedge clk) disable iff (!rst) !(push && count == QD));
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: table vectors, directed corner sequences and random traffic
// checked against a queue-based reference model of the fetch unit.
module tb_ifetch_queue;
   logic        clk = 0, rst = 1, prog_mode = 0, redirect_valid = 0, out_ready = 0;
   logic [31:0] redirect_pc = 0, imem_rdata = 0;
   logic        imem_en, out_valid, fetch_err;
   logic [13:0] imem_addr;
   logic [31:0] out_instr, out_pc, out_pc_plus4;
   logic [2:0]  q_count;
   int          vectors = 0, miscompares = 0;

   logic [31:0] mq[$];
   bit          minfl, merr;
   logic [31:0] mreq, mfpc;

   typedef struct {bit rdy; bit en; bit v; logic [31:0] pc; int cnt;} vec_t;
   vec_t tbl[16];

   ifetch_queue dut (
      .clk(clk), .rst(rst), .prog_mode(prog_mode), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .imem_en(imem_en), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
      .q_count(q_count), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(logic [31:0] pc);
      return 32'h1000_0000 + {18'd0, pc[15:2]};
   endfunction

   task automatic chk(string n, logic [31:0] a, logic [31:0] e);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask

   task automatic m_reset;
      mq.delete();
      minfl = 0; merr = 0; mfpc = 0; mreq = 0;
   endtask

   task automatic model_check;
      int sz = mq.size();
      bit e_en = !(prog_mode | redirect_valid) && (sz + int'(minfl) < 4);
      chk("imem_en", 32'(imem_en), 32'(e_en));
      chk("imem_addr", 32'(imem_addr), 32'(mfpc[15:2]));
      chk("out_valid", 32'(out_valid), 32'(sz != 0));
      chk("q_count", 32'(q_count), 32'(sz));
      chk("fetch_err", 32'(fetch_err), 32'(merr));
      if (sz != 0) begin
         chk("out_pc", out_pc, mq[0]);
         chk("out_instr", out_instr, word_of(mq[0]));
         chk("out_pc_plus4", out_pc_plus4, mq[0] + 32'd4);
      end
   endtask

   task automatic apply(bit pm, bit rv, logic [31:0] rpc, bit rdy);
      prog_mode = pm; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
      #1;
      model_check();
   endtask

   task automatic tick;
      bit fl = prog_mode | redirect_valid;
      int sz = mq.size();
      bit en = !fl && (sz + int'(minfl) < 4);
      bit pop = sz != 0 && out_ready && !fl;
      bit en_s = imem_en;
      logic [13:0] a_s = imem_addr;
      if (fl) mq.delete();
      else begin
         if (pop) void'(mq.pop_front());
         if (minfl) mq.push_back(mreq);
      end
      if (prog_mode) mfpc = 0;
      else if (redirect_valid) begin
         mfpc = {redirect_pc[31:2], 2'b00};
         if (redirect_pc[1:0] != 0) merr = 1;
      end else if (en) begin
         mreq = mfpc;
         mfpc = mfpc + 32'd4;
      end
      minfl = en;
      @(posedge clk);
      #1 imem_rdata = en_s ? 32'h1000_0000 + 32'(a_s) : $urandom;
      @(negedge clk);
   endtask

   task automatic wait_pc(logic [31:0] exp, string n);
      bit seen = 0;
      for (int k = 0; k < 8 && !seen; k++) begin
         apply(0, 0, 0, 1);
         if (out_valid) begin
            seen = 1;
            chk(n, out_pc, exp);
         end
         tick();
      end
      if (!seen) begin
         vectors++; miscompares++;
         $display("FAIL %s: out_valid never rose within 8 cycles", n);
      end
   endtask

   initial begin
      tbl[0] = '{0, 1, 0, 0, 0};
      tbl[1] = '{0, 1, 0, 0, 0};
      tbl[2] = '{0, 1, 1, 0, 1};
      tbl[3] = '{0, 1, 1, 0, 2};
      tbl[4] = '{0, 0, 1, 0, 3};
      for (int i = 5; i < 10; i++) tbl[i] = '{0, 0, 1, 0, 4};
      tbl[10] = '{1, 0, 1, 32'h00, 4};
      tbl[11] = '{1, 1, 1, 32'h04, 3};
      tbl[12] = '{1, 1, 1, 32'h08, 2};
      tbl[13] = '{1, 1, 1, 32'h0C, 2};
      tbl[14] = '{1, 1, 1, 32'h10, 2};
      tbl[15] = '{1, 1, 1, 32'h14, 2};
      m_reset();
      #1 rst = 0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_en", 32'(imem_en), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_cnt", 32'(q_count), 0);
      chk("rst_err", 32'(fetch_err), 0);
      @(negedge clk);
      rst = 1;
      // reset, backpressure to a full queue, then in-order drain at full rate
      for (int i = 0; i < 16; i++) begin
         apply(0, 0, 0, tbl[i].rdy);
         chk("tbl_en", 32'(imem_en), 32'(tbl[i].en));
         chk("tbl_valid", 32'(out_valid), 32'(tbl[i].v));
         if (tbl[i].v) chk("tbl_pc", out_pc, tbl[i].pc);
         chk("tbl_cnt", 32'(q_count), 32'(tbl[i].cnt));
         tick();
      end
      // redirect with three queued entries and one read in flight
      apply(0, 0, 0, 0); tick();
      apply(0, 1, 32'h100, 1);
      chk("t3_cnt_before", 32'(q_count), 3);
      chk("t3_en", 32'(imem_en), 0);
      tick();
      apply(0, 0, 0, 1);
      chk("t3_cnt_after", 32'(q_count), 0);
      chk("t3_valid1", 32'(out_valid), 0);
      tick();
      apply(0, 0, 0, 1);
      chk("t3_valid2", 32'(out_valid), 0);
      tick();
      apply(0, 0, 0, 1);
      chk("t3_valid3", 32'(out_valid), 1);
      chk("t3_pc", out_pc, 32'h100);
      tick();
      // misaligned redirect
      apply(0, 1, 32'h102, 1); tick();
      apply(0, 0, 0, 1);
      chk("t4_err", 32'(fetch_err), 1);
      tick();
      wait_pc(32'h100, "t4_pc");
      repeat (3) begin
         apply(0, 0, 0, 1);
         chk("t4_err_sticky", 32'(fetch_err), 1);
         tick();
      end
      // programming-mode hold
      for (int k = 0; k < 5; k++) begin
         apply(1, 0, 0, 1);
         chk("t5_en", 32'(imem_en), 0);
         if (k > 0) chk("t5_valid", 32'(out_valid), 0);
         tick();
      end
      wait_pc(32'h0, "t5_pc");
      // random traffic
      for (int i = 0; i < 1500; i++) begin
         bit pm = $urandom_range(0, 29) == 0;
         bit rv = !pm && $urandom_range(0, 11) == 0;
         logic [31:0] rpc = (32'($urandom_range(0, 1023)) & ~32'h3) |
                            ($urandom_range(0, 15) == 0 ? 32'h2 : 32'h0);
         apply(pm, rv, rpc, $urandom_range(0, 9) < 7);
         tick();
      end
      // asynchronous reset with three entries queued
      apply(1, 0, 0, 0); tick();
      repeat (4) begin apply(0, 0, 0, 0); tick(); end
      apply(0, 0, 0, 0);
      chk("t6_cnt_before", 32'(q_count), 3);
      #2 rst = 0;
      #1;
      chk("t6_en", 32'(imem_en), 0);
      chk("t6_valid", 32'(out_valid), 0);
      chk("t6_cnt", 32'(q_count), 0);
      chk("t6_err", 32'(fetch_err), 0);
      m_reset();
      @(negedge clk);
      rst = 1;
      wait_pc(32'h0, "t6_pc");
      apply(0, 0, 0, 1);
      chk("t6_pc_next", out_pc, 32'h4);
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
